// File: rtl/timer_down_8bit_pkg.sv
// timer_pkg: shared definitions for the down-counting interval timer.
//   state_t      : controller states (IDLE, RUN, HOLD, DONE)
//   MODE_ONESHOT : stop in DONE at expiry
//   MODE_RELOAD  : restart from the reload register at expiry
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/timer_down_8bit_tick_gen.sv
// tick_gen: clock prescaler for the down timer.
//   clk        : system clock
//   clr        : synchronous active-low reset
//   en         : advance the prescaler this cycle
//   sync_clear : force the prescaler back to 0 (load)
//   tick       : one count tick, asserted when enabled at DIV-1
module tick_gen #(
  parameter int unsigned DIV = 1,
  parameter int unsigned PW  = 8
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  input  logic sync_clear,
  output logic tick
);

  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] pre;

  assign tick = en && (pre == LAST);

  always_ff @(posedge clk) begin
    if (!clr) begin
      pre <= '0;
    end else if (sync_clear) begin
      pre <= '0;
    end else if (en) begin
      pre <= tick ? '0 : pre + PW'(1);
    end
  end

endmodule

// File: rtl/timer_down_8bit.sv
// timer_down_8bit: programmable down-counting interval timer.
//   clk  : system clock (posedge)
//   clr  : synchronous active-low reset
//   l    : load strobe, d -> count and reload registers
//   s_s  : start/stop level (1 = run, 0 = pause)
//   mode : 0 = one-shot, 1 = auto-reload
//   d    : load value
//   c    : current count (registered)
//   tc   : one-cycle terminal-count pulse (registered)
//   busy : high while in RUN
module timer_down_8bit
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV   = 1,
  parameter int unsigned PW    = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             l,
  input  logic             s_s,
  input  logic             mode,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] c,
  output logic             tc,
  output logic             busy
);

  state_t           state, state_n;
  logic [WIDTH-1:0] reload, reload_n, c_n;
  logic             tc_n;
  logic             tick;
  logic             pre_en;

  // s_s is folded into the enable so the prescaler freezes on the
  // RUN->HOLD edge together with c; resuming then loses no tick.
  assign pre_en = (state == RUN) && s_s && !l;

  tick_gen #(
    .DIV (DIV),
    .PW  (PW)
  ) u_tick_gen (
    .clk        (clk),
    .clr        (clr),
    .en         (pre_en),
    .sync_clear (l),
    .tick       (tick)
  );

  assign busy = (state == RUN);

  always_comb begin
    state_n  = state;
    c_n      = c;
    reload_n = reload;
    tc_n     = 1'b0;
    if (l) begin
      c_n      = d;
      reload_n = d;
      state_n  = s_s ? RUN : HOLD;
    end else begin
      unique case (state)
        RUN: begin
          if (!s_s) begin
            state_n = HOLD;
          end else if (tick) begin
            if (c <= WIDTH'(1)) begin
              tc_n = 1'b1;
              if (mode == MODE_RELOAD) begin
                c_n = reload;
              end else begin
                c_n     = '0;
                state_n = DONE;
              end
            end else begin
              c_n = c - WIDTH'(1);
            end
          end
        end
        HOLD: begin
          if (s_s) state_n = RUN;
        end
        default: ;  // IDLE and DONE wait for a load
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state  <= IDLE;
      c      <= '0;
      reload <= '0;
      tc     <= 1'b0;
    end else begin
      state  <= state_n;
      c      <= c_n;
      reload <= reload_n;
      tc     <= tc_n;
    end
  end

endmodule
